// File: rtl/ram_fifo_pkg.sv
// Shared widths, types and skid-buffer state encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_st_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output skid buffer: captures RAM read data and presents the head of the FIFO.
module fifo_skid_buf
    import ram_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cap_i,
    input  data_t      cap_data_i,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output data_t      out_data_o,
    output logic       pop_c_o,
    output logic [1:0] occ_o
);

    buf_st_e state_q, state_d;
    data_t   head_q, head_d;
    data_t   tail_q, tail_d;
    logic    out_valid_q, out_valid_d;
    logic    pop_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BUF_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop_c   = out_valid_q && out_ready_i;
        case (state_q)
            BUF_EMPTY: begin
                if (cap_i) begin
                    head_d  = cap_data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (cap_i && !pop_c) begin
                    tail_d  = cap_data_i;
                    state_d = BUF_TWO;
                end else if (pop_c && !cap_i) begin
                    state_d = BUF_EMPTY;
                end else if (cap_i && pop_c) begin
                    head_d = cap_data_i;
                end
            end
            BUF_TWO: begin
                // A capture here can only coincide with a pop; keep both entries in order.
                if (pop_c) begin
                    head_d = tail_q;
                    if (cap_i) begin
                        tail_d = cap_data_i;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        out_valid_d = (state_d != BUF_EMPTY);
    end

    always_comb begin
        occ_o = 2'd0;
        case (state_q)
            BUF_ONE: occ_o = 2'd1;
            BUF_TWO: occ_o = 2'd2;
            default: occ_o = 2'd0;
        endcase
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = head_q;
    assign pop_c_o     = pop_c;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external 16x8 sync dual-port RAM with a 2-entry output skid buffer.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ram_we,
    output logic [AW-1:0] ram_w_add,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_re,
    output logic [AW-1:0] ram_r_add,
    input  logic [DW-1:0] ram_data_out
);

    addr_t      wr_ptr_q, wr_ptr_d;
    addr_t      rd_ptr_q, rd_ptr_d;
    cnt_t       mem_cnt_q, mem_cnt_d;
    cnt_t       count_q, count_d;
    logic       rd_pend_q;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    logic       pop_c;
    logic [1:0] buf_occ;
    logic [2:0] buf_occ_d;

    fifo_skid_buf u_skid (
        .clk         (clk),
        .reset       (reset),
        .cap_i       (rd_pend_q),
        .cap_data_i  (ram_data_out),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .pop_c_o     (pop_c),
        .occ_o       (buf_occ)
    );

    // Next buffer occupancy doubles as the read credit: issue only if it stays below two.
    always_comb begin
        buf_occ_d = 3'(buf_occ) + 3'(rd_pend_q) - 3'(pop_c);
        in_ready  = !reset && !full_q;
        ram_we    = in_valid && in_ready;
        ram_re    = !reset && (mem_cnt_q != '0) && (buf_occ_d < 3'd2);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + addr_t'(ram_we);
        rd_ptr_d  = rd_ptr_q + addr_t'(ram_re);
        mem_cnt_d = mem_cnt_q + cnt_t'(ram_we) - cnt_t'(ram_re);
        count_d   = mem_cnt_d + cnt_t'(ram_re) + cnt_t'(buf_occ_d);
        full_d    = (mem_cnt_d == cnt_t'(DEPTH));
        empty_d   = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            count_q   <= count_d;
            rd_pend_q <= ram_re;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    assign ram_w_add   = wr_ptr_q;
    assign ram_data_in = in_data;
    assign ram_r_add   = rd_ptr_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule
